// File: rtl/dm_responder.sv
// Data-memory bus responder: one request at a time, word read or byte-masked write,
// response after WAIT_STATES wait cycles. Define DM_ERR_EN to add the rsp_err port and address checking.
module dm_responder #(
  parameter int          WORD_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic                    req_we,
  input  logic [WORD_WIDTH/8-1:0] req_be,
  input  logic [WORD_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WORD_WIDTH-1:0]   rsp_rdata
`ifdef DM_ERR_EN
  ,
  output logic                    rsp_err
`endif
);

  localparam int         BE_W     = WORD_WIDTH / 8;
  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [7:0] CNT_INIT = (WAIT_STATES == 0) ? 8'd0 : 8'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [31:0]             addr_q, addr_d;
  logic                    we_q, we_d;
  logic [BE_W-1:0]         be_q, be_d;
  logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0]   rdata_q, rdata_d;

  logic [WORD_WIDTH-1:0]   mem [DEPTH];

  logic                    do_access;
  logic                    mem_we;
  logic [31:0]             acc_addr;
  logic                    acc_we;
  logic [BE_W-1:0]         acc_be;
  logic [WORD_WIDTH-1:0]   acc_wdata;
  logic [31:0]             acc_off;
  logic [ADDR_WIDTH-1:0]   acc_idx;

`ifdef DM_ERR_EN
  localparam logic [63:0]  MEM_BYTES = 64'(DEPTH) * 64'd4;
  logic                    err_q, err_d;
  logic                    acc_bad;
`endif

  // With zero wait states the access happens on the accepting edge, so it must use the live request.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_addr  = req_addr;
      acc_we    = req_we;
      acc_be    = req_be;
      acc_wdata = req_wdata;
    end else begin
      acc_addr  = addr_q;
      acc_we    = we_q;
      acc_be    = be_q;
      acc_wdata = wdata_q;
    end
    acc_off = acc_addr - BASE_ADDR;
    acc_idx = ADDR_WIDTH'(acc_off >> 2);
`ifdef DM_ERR_EN
    acc_bad = (acc_addr[1:0] != 2'b00) || (acc_addr < BASE_ADDR) ||
              ({32'd0, acc_off} >= MEM_BYTES);
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    do_access = 1'b0;
`ifdef DM_ERR_EN
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          be_d    = req_be;
          wdata_d = req_wdata;
          if (WAIT_STATES == 0) begin
            state_d   = S_RESP;
            do_access = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d   = S_RESP;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_access) begin
`ifdef DM_ERR_EN
      rdata_d = (acc_we || acc_bad) ? '0 : mem[acc_idx];
      err_d   = acc_bad;
`else
      rdata_d = acc_we ? '0 : mem[acc_idx];
`endif
    end
  end

`ifdef DM_ERR_EN
  assign mem_we  = do_access && acc_we && !acc_bad;
  assign rsp_err = err_q;
`else
  assign mem_we  = do_access && acc_we;
`endif

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= '0;
`ifdef DM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef DM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Request capture registers only matter once a transaction is in flight, so they carry no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    be_q    <= be_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule
